// File: rtl/gobou_img_arb_pkg.sv
// gobou_img_arb_pkg
//   Shared gobou image-memory constants and the arbiter state encoding.
//   DWIDTH_DEF   : image memory word width
//   IMGSIZE_DEF  : image memory address width (depth 2**IMGSIZE_DEF)
//   HOST_GAP_DEF : core reads between forced host slots (GOBOU_IMG_ARB_FAIR_EN builds)
package gobou_img_arb_pkg;

   localparam int unsigned DWIDTH_DEF   = 16;
   localparam int unsigned IMGSIZE_DEF  = 12;
   localparam int unsigned HOST_GAP_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOST  = 2'd1,
      ST_BURST = 2'd2
   } arb_state_e;

endpackage

// File: rtl/gobou_img_arb_if.sv
// gobou_img_arb_if
//   Bundles the host, core and image-memory signals of the image arbiter.
//   slave  : arbiter side (consumes requests and mem_rdata, drives the rest)
//   master : environment side (host, core and memory)
//   Host   : host_req/host_we/host_addr/host_wdata -> host_ack/host_rvalid/host_rdata
//   Core   : core_start/core_base/core_len -> core_busy/core_rvalid/core_rdata/core_done
//   Memory : mem_we/mem_addr/mem_wdata -> mem_rdata (registered address, 1-cycle latency)
interface gobou_img_arb_if
   import gobou_img_arb_pkg::*;
#(
   parameter int unsigned DWIDTH  = DWIDTH_DEF,
   parameter int unsigned IMGSIZE = IMGSIZE_DEF
) ();

   logic               host_req;
   logic               host_we;
   logic [IMGSIZE-1:0] host_addr;
   logic [DWIDTH-1:0]  host_wdata;
   logic               host_ack;
   logic               host_rvalid;
   logic [DWIDTH-1:0]  host_rdata;

   logic               core_start;
   logic [IMGSIZE-1:0] core_base;
   logic [IMGSIZE-1:0] core_len;
   logic               core_busy;
   logic               core_rvalid;
   logic [DWIDTH-1:0]  core_rdata;
   logic               core_done;

   logic               mem_we;
   logic [IMGSIZE-1:0] mem_addr;
   logic [DWIDTH-1:0]  mem_wdata;
   logic [DWIDTH-1:0]  mem_rdata;

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      output host_ack, host_rvalid, host_rdata,
      input  core_start, core_base, core_len,
      output core_busy, core_rvalid, core_rdata, core_done,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      input  host_ack, host_rvalid, host_rdata,
      output core_start, core_base, core_len,
      input  core_busy, core_rvalid, core_rdata, core_done,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/gobou_img_arb_seq.sv
// gobou_img_arb_seq
//   Burst address sequencer: latches base/length, walks the word index and
//   wraps the address modulo 2**IMGSIZE.
//   clk, xrst : clock, synchronous active-low reset
//   load      : latch base_in/len_in; index 0 is issued by the caller this cycle
//   adv       : the current address (addr) was issued, step the index
//   issue     : another burst read is pending
//   last      : the pending read is the final one of the burst
//   addr      : address of the pending read
module gobou_img_arb_seq
   import gobou_img_arb_pkg::*;
#(
   parameter int unsigned IMGSIZE = IMGSIZE_DEF
) (
   input  logic               clk,
   input  logic               xrst,
   input  logic               load,
   input  logic               adv,
   input  logic [IMGSIZE-1:0] base_in,
   input  logic [IMGSIZE-1:0] len_in,
   output logic               issue,
   output logic               last,
   output logic [IMGSIZE-1:0] addr
);

   logic [IMGSIZE-1:0] base_q, base_d;
   logic [IMGSIZE-1:0] len_q,  len_d;
   logic [IMGSIZE-1:0] idx_q,  idx_d;

   // Outputs depend on state only, so the caller may use them to decide adv.
   always_comb begin
      issue  = (idx_q != len_q);
      last   = (idx_q == len_q - IMGSIZE'(1));
      addr   = base_q + idx_q;
      base_d = base_q;
      len_d  = len_q;
      idx_d  = idx_q;
      if (load) begin
         // Index 0 goes out alongside the load, so the next pending read is 1.
         base_d = base_in;
         len_d  = len_in;
         idx_d  = IMGSIZE'(1);
      end else if (adv) begin
         idx_d  = idx_q + IMGSIZE'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!xrst) begin
         base_q <= '0;
         len_q  <= '0;
         idx_q  <= '0;
      end else begin
         base_q <= base_d;
         len_q  <= len_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/gobou_img_arb.sv
// gobou_img_arb
//   Arbiter/sequencer sharing the single-port gobou image memory between
//   host single-word accesses and core sequential burst reads.
//   clk, xrst : clock, synchronous active-low reset
//   bus       : gobou_img_arb_if.slave (host, core and memory signal groups)
//   Memory commands are registered: a grant decided in cycle t drives the
//   memory in t+1 and read data returns on mem_rdata in t+2.
//   Optional macro GOBOU_IMG_ARB_FAIR_EN: inserts a host slot into a burst
//   after every HOST_GAP consecutive core reads while host_req is held.
module gobou_img_arb
   import gobou_img_arb_pkg::*;
#(
   parameter int unsigned DWIDTH  = DWIDTH_DEF,
   parameter int unsigned IMGSIZE = IMGSIZE_DEF
`ifdef GOBOU_IMG_ARB_FAIR_EN
   ,
   parameter int unsigned HOST_GAP = HOST_GAP_DEF
`endif
) (
   input logic            clk,
   input logic            xrst,
   gobou_img_arb_if.slave bus
);

   arb_state_e         state_q, state_d;
   logic               mem_we_q, mem_we_d;
   logic [IMGSIZE-1:0] mem_addr_q, mem_addr_d;
   logic [DWIDTH-1:0]  mem_wdata_q, mem_wdata_d;
   logic               host_ack_q, host_ack_d;
   logic               host_rvalid_q, host_rvalid_d;
   logic               core_rd_q, core_rd_d;       // memory bus carries a core read
   logic               core_last_q, core_last_d;   // ... and it is the burst's final one
   logic               core_rvalid_q, core_rvalid_d;
   logic               core_done_q, core_done_d;
   logic               core_busy_q, core_busy_d;

   logic               seq_load, seq_adv, seq_issue, seq_last;
   logic [IMGSIZE-1:0] seq_addr;

`ifdef GOBOU_IMG_ARB_FAIR_EN
   localparam int unsigned GAP_W = $clog2(HOST_GAP + 1);
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               resume_q, resume_d;         // HOST slot was taken out of a burst
`else
`endif

   gobou_img_arb_seq #(
      .IMGSIZE (IMGSIZE)
   ) u_seq (
      .clk     (clk),
      .xrst    (xrst),
      .load    (seq_load),
      .adv     (seq_adv),
      .base_in (bus.core_base),
      .len_in  (bus.core_len),
      .issue   (seq_issue),
      .last    (seq_last),
      .addr    (seq_addr)
   );

   always_comb begin
      state_d       = state_q;
      mem_we_d      = 1'b0;
      mem_addr_d    = '0;
      mem_wdata_d   = '0;
      host_ack_d    = 1'b0;
      core_rd_d     = 1'b0;
      core_last_d   = 1'b0;
      seq_load      = 1'b0;
      seq_adv       = 1'b0;
      // Response flags follow the command that is on the memory bus this cycle.
      host_rvalid_d = (state_q == ST_HOST) && !mem_we_q;
      core_rvalid_d = core_rd_q;
      core_done_d   = core_rd_q && core_last_q;
      // Busy holds through the cycle of the final rvalid/done.
      core_busy_d   = core_busy_q && !core_done_q;
`ifdef GOBOU_IMG_ARB_FAIR_EN
      gap_d         = gap_q;
      resume_d      = 1'b0;
`else
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (bus.core_start && !core_busy_q && (bus.core_len != '0)) begin
               // Index 0 is issued straight from the start inputs.
               seq_load    = 1'b1;
               state_d     = ST_BURST;
               core_busy_d = 1'b1;
               mem_addr_d  = bus.core_base;
               core_rd_d   = 1'b1;
               core_last_d = (bus.core_len == IMGSIZE'(1));
`ifdef GOBOU_IMG_ARB_FAIR_EN
               gap_d       = bus.host_req ? GAP_W'(1) : '0;
`else
`endif
            end else if (bus.core_start && !core_busy_q) begin
               core_done_d = 1'b1;
            end else if (bus.host_req) begin
               state_d     = ST_HOST;
               mem_we_d    = bus.host_we;
               mem_addr_d  = bus.host_addr;
               mem_wdata_d = bus.host_wdata;
               host_ack_d  = 1'b1;
            end
         end

         ST_HOST: begin
            state_d = ST_IDLE;
`ifdef GOBOU_IMG_ARB_FAIR_EN
            if (resume_q && seq_issue) begin
               state_d     = ST_BURST;
               seq_adv     = 1'b1;
               mem_addr_d  = seq_addr;
               core_rd_d   = 1'b1;
               core_last_d = seq_last;
               gap_d       = bus.host_req ? GAP_W'(1) : '0;
            end
`else
`endif
         end

         ST_BURST: begin
`ifdef GOBOU_IMG_ARB_FAIR_EN
            if (bus.host_req && seq_issue && (gap_q == GAP_W'(HOST_GAP))) begin
               // Stall the burst for one host slot; the index is held.
               state_d     = ST_HOST;
               mem_we_d    = bus.host_we;
               mem_addr_d  = bus.host_addr;
               mem_wdata_d = bus.host_wdata;
               host_ack_d  = 1'b1;
               resume_d    = 1'b1;
               gap_d       = '0;
            end else if (seq_issue) begin
               seq_adv     = 1'b1;
               mem_addr_d  = seq_addr;
               core_rd_d   = 1'b1;
               core_last_d = seq_last;
               gap_d       = bus.host_req ? gap_q + GAP_W'(1) : '0;
            end else begin
               state_d     = ST_IDLE;
            end
`else
            if (seq_issue) begin
               seq_adv     = 1'b1;
               mem_addr_d  = seq_addr;
               core_rd_d   = 1'b1;
               core_last_d = seq_last;
            end else begin
               state_d     = ST_IDLE;
            end
`endif
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!xrst) begin
         state_q       <= ST_IDLE;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         host_ack_q    <= 1'b0;
         host_rvalid_q <= 1'b0;
         core_rd_q     <= 1'b0;
         core_last_q   <= 1'b0;
         core_rvalid_q <= 1'b0;
         core_done_q   <= 1'b0;
         core_busy_q   <= 1'b0;
`ifdef GOBOU_IMG_ARB_FAIR_EN
         gap_q         <= '0;
         resume_q      <= 1'b0;
`else
`endif
      end else begin
         state_q       <= state_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         host_ack_q    <= host_ack_d;
         host_rvalid_q <= host_rvalid_d;
         core_rd_q     <= core_rd_d;
         core_last_q   <= core_last_d;
         core_rvalid_q <= core_rvalid_d;
         core_done_q   <= core_done_d;
         core_busy_q   <= core_busy_d;
`ifdef GOBOU_IMG_ARB_FAIR_EN
         gap_q         <= gap_d;
         resume_q      <= resume_d;
`else
`endif
      end
   end

   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.host_ack    = host_ack_q;
   assign bus.host_rvalid = host_rvalid_q;
   assign bus.core_rvalid = core_rvalid_q;
   assign bus.core_done   = core_done_q;
   assign bus.core_busy   = core_busy_q;
   // Memory output is already registered; gate it so idle data reads as 0.
   assign bus.host_rdata  = host_rvalid_q ? bus.mem_rdata : '0;
   assign bus.core_rdata  = core_rvalid_q ? bus.mem_rdata : '0;

endmodule
